// File: rtl/mem_wr_pkg.sv
// Package shared by the pipeline stages: the memory-write FSM state encoding,
// the store-strobe width and the stage-register layout.
package mem_wr_pkg;

  localparam int unsigned STRB_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STORE = 1'b1
  } state_e;

  // One retiring instruction together with its optional store request.
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              valid;
    logic [4:0]        reg_d;
    logic [31:0]       reg_d_v;
    logic              store_wren;
    logic [31:0]       store_addr;
    logic [STRB_W-1:0] store_strb;
    logic [31:0]       store_data;
  } stage_t;

endpackage

// File: rtl/mem_wr_if.sv
// Data-memory write channel (valid/ready).
//   master: drives DATA_WVALID/WADDR/WSTRB/WDATA, samples DATA_WREADY
//   slave : the memory side, drives DATA_WREADY
interface mem_wr_if;

  logic                            DATA_WVALID;
  logic [31:0]                     DATA_WADDR;
  logic [mem_wr_pkg::STRB_W-1:0]   DATA_WSTRB;
  logic [31:0]                     DATA_WDATA;
  logic                            DATA_WREADY;

  modport master (
    output DATA_WVALID, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
    input  DATA_WREADY
  );

  modport slave (
    input  DATA_WVALID, DATA_WADDR, DATA_WSTRB, DATA_WDATA,
    output DATA_WREADY
  );

endinterface

// File: rtl/mem_wr_retire_cnt.sv
// Free-running count of retired instructions, wraps at 2^32.
//   clk_i : clock
//   rst_i : synchronous active-high reset, clears the count
//   inc_i : add one at this edge
//   cnt_o : current count
module retire_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + 32'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_wr.sv
// Memory-write / writeback pipeline stage.
// Latches the instruction leaving the memory-read stage, issues its store on
// the data-memory write channel (freezing upstream while the memory is not
// ready), and presents the register-file writeback / forwarding source.
//   CLK, RST        : clock, synchronous active-high reset
//   M_*             : incoming instruction and store request
//   dmem            : data-memory write channel (master side)
//   STALL_REQ       : freeze upstream stages (store pending, memory not ready)
//   W_*             : latched instruction, register writeback enable
//   W_RETIRED       : retired-instruction count
module mem_wr
  import mem_wr_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,

  input  logic [31:0]       M_PC,
  input  logic [31:0]       M_INST,
  input  logic              M_VALID,
  input  logic [4:0]        M_REG_D,
  input  logic [31:0]       M_REG_D_V,
  input  logic              M_STORE_WREN,
  input  logic [31:0]       M_STORE_ADDR,
  input  logic [STRB_W-1:0] M_STORE_STRB,
  input  logic [31:0]       M_STORE_DATA,

  mem_wr_if.master          dmem,

  output logic              STALL_REQ,

  output logic [31:0]       W_PC,
  output logic [31:0]       W_INST,
  output logic              W_VALID,
  output logic [4:0]        W_REG_D,
  output logic [31:0]       W_REG_D_V,
  output logic              W_REG_WREN,
  output logic [31:0]       W_RETIRED
);

  state_e state_q, state_d;
  stage_t stage_q, stage_d;
  logic   xfer;
  logic   retire;

  // Only a pending store can stall; upstream inputs never feed this path.
  assign STALL_REQ = (state_q == ST_STORE) && !dmem.DATA_WREADY;
  assign xfer      = (state_q == ST_STORE) &&  dmem.DATA_WREADY;

  always_comb begin
    stage_d = stage_q;
    state_d = state_q;
    if (!STALL_REQ) begin
      stage_d.pc         = M_PC;
      stage_d.inst       = M_INST;
      stage_d.valid      = M_VALID;
      stage_d.reg_d      = M_REG_D;
      stage_d.reg_d_v    = M_REG_D_V;
      stage_d.store_wren = M_STORE_WREN;
      stage_d.store_addr = M_STORE_ADDR;
      stage_d.store_strb = M_STORE_STRB;
      stage_d.store_data = M_STORE_DATA;
      // A completing store followed by another store goes straight back to
      // STORE, so back-to-back stores issue without a bubble.
      state_d = (M_VALID && M_STORE_WREN) ? ST_STORE : ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  assign dmem.DATA_WVALID = (state_q == ST_STORE);
  assign dmem.DATA_WADDR  = stage_q.store_addr;
  assign dmem.DATA_WSTRB  = stage_q.store_strb;
  assign dmem.DATA_WDATA  = stage_q.store_data;

  assign W_PC       = stage_q.pc;
  assign W_INST     = stage_q.inst;
  assign W_VALID    = stage_q.valid;
  assign W_REG_D    = stage_q.reg_d;
  assign W_REG_D_V  = stage_q.reg_d_v;
  // Non-stores never stall, so this is high for exactly one cycle each.
  assign W_REG_WREN = stage_q.valid && !stage_q.store_wren && (stage_q.reg_d != 5'd0);

  // Stores retire on their transfer edge; everything else on its only edge.
  assign retire = stage_q.valid && (!stage_q.store_wren || xfer);

  retire_cnt u_retire (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (retire),
    .cnt_o (W_RETIRED)
  );

endmodule

// File: tb/tb_mem_wr.sv
module tb_mem_wr;
  import mem_wr_pkg::*;

  logic              CLK;
  logic              RST;
  logic [31:0]       M_PC, M_INST, M_REG_D_V, M_STORE_ADDR, M_STORE_DATA;
  logic              M_VALID, M_STORE_WREN;
  logic [4:0]        M_REG_D;
  logic [STRB_W-1:0] M_STORE_STRB;
  logic              STALL_REQ;
  logic [31:0]       W_PC, W_INST, W_REG_D_V, W_RETIRED;
  logic              W_VALID, W_REG_WREN;
  logic [4:0]        W_REG_D;

  mem_wr_if dmem_if ();

  mem_wr dut (
    .CLK          (CLK),
    .RST          (RST),
    .M_PC         (M_PC),
    .M_INST       (M_INST),
    .M_VALID      (M_VALID),
    .M_REG_D      (M_REG_D),
    .M_REG_D_V    (M_REG_D_V),
    .M_STORE_WREN (M_STORE_WREN),
    .M_STORE_ADDR (M_STORE_ADDR),
    .M_STORE_STRB (M_STORE_STRB),
    .M_STORE_DATA (M_STORE_DATA),
    .dmem         (dmem_if.master),
    .STALL_REQ    (STALL_REQ),
    .W_PC         (W_PC),
    .W_INST       (W_INST),
    .W_VALID      (W_VALID),
    .W_REG_D      (W_REG_D),
    .W_REG_D_V    (W_REG_D_V),
    .W_REG_WREN   (W_REG_WREN),
    .W_RETIRED    (W_RETIRED)
  );

  int n_cmp = 0;
  int n_err = 0;
  int xfers = 0;
  logic [31:0] last_addr = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs are stable from negedge+2 until the next posedge, so a handshake
  // seen here is the transfer that the coming edge performs.
  always @(negedge CLK) begin
    #2;
    if (dmem_if.DATA_WVALID && dmem_if.DATA_WREADY) begin
      xfers++;
      last_addr = dmem_if.DATA_WADDR;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] rdv, input logic st, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] data);
    M_VALID      = vld;
    M_PC         = pc;
    M_INST       = pc ^ 32'h0000_0013;
    M_REG_D      = rd;
    M_REG_D_V    = rdv;
    M_STORE_WREN = st;
    M_STORE_ADDR = addr;
    M_STORE_STRB = strb;
    M_STORE_DATA = data;
  endtask

  initial begin
    // Reset held two cycles with a valid store presented.
    RST = 1'b1;
    dmem_if.DATA_WREADY = 1'b0;
    drive(1'b1, 32'h0000_0800, 5'd5, 32'h1111, 1'b1, 32'h80, 4'hF, 32'h99);
    repeat (2) @(negedge CLK);
    check("rst_wvalid", {31'd0, dmem_if.DATA_WVALID}, 32'd0);
    check("rst_stall",  {31'd0, STALL_REQ}, 32'd0);
    check("rst_wvld",   {31'd0, W_VALID}, 32'd0);
    check("rst_wren",   {31'd0, W_REG_WREN}, 32'd0);
    check("rst_ret",    W_RETIRED, 32'd0);
    check("rst_pc",     W_PC, 32'd0);

    // ALU op to x5.
    RST = 1'b0;
    drive(1'b1, 32'h0000_1000, 5'd5, 32'h1234, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge CLK);
    check("alu_wren",  {31'd0, W_REG_WREN}, 32'd1);
    check("alu_rd",    {27'd0, W_REG_D}, 32'd5);
    check("alu_rdv",   W_REG_D_V, 32'h1234);
    check("alu_pc",    W_PC, 32'h1000);
    check("alu_inst",  W_INST, 32'h0000_1013);
    check("alu_stall", {31'd0, STALL_REQ}, 32'd0);
    check("alu_ret0",  W_RETIRED, 32'd0);

    // Store with three wait states.
    drive(1'b1, 32'h0000_1004, 5'd7, 32'h0, 1'b1, 32'h100, 4'h3, 32'hBEEF);
    @(negedge CLK);
    check("alu_ret1",  W_RETIRED, 32'd1);
    check("st_wren",   {31'd0, W_REG_WREN}, 32'd0);
    check("st_pc",     W_PC, 32'h1004);
    drive(1'b1, 32'h0000_2000, 5'd9, 32'hDEAD, 1'b0, 32'h200, 4'hC, 32'h5555);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge CLK);
      check("wait_wvalid", {31'd0, dmem_if.DATA_WVALID}, 32'd1);
      check("wait_addr",   dmem_if.DATA_WADDR, 32'h100);
      check("wait_strb",   {28'd0, dmem_if.DATA_WSTRB}, 32'h3);
      check("wait_data",   dmem_if.DATA_WDATA, 32'hBEEF);
      check("wait_stall",  {31'd0, STALL_REQ}, 32'd1);
      check("wait_hold",   W_PC, 32'h1004);
      check("wait_ret",    W_RETIRED, 32'd1);
      check("wait_xfer",   xfers, 32'd0);
    end
    dmem_if.DATA_WREADY = 1'b1;
    #1;
    check("rdy_stall", {31'd0, STALL_REQ}, 32'd0);
    // Bubble carrying stale store fields.
    drive(1'b0, 32'h0000_2004, 5'd3, 32'h7, 1'b1, 32'h400, 4'hF, 32'hAAAA);
    @(negedge CLK);
    check("xfer_cnt",    xfers, 32'd1);
    check("xfer_addr",   last_addr, 32'h100);
    check("st_ret",      W_RETIRED, 32'd2);
    check("bub_wvalid",  {31'd0, dmem_if.DATA_WVALID}, 32'd0);
    check("bub_wren",    {31'd0, W_REG_WREN}, 32'd0);

    // Write to x0, WREADY still high in IDLE.
    drive(1'b1, 32'h0000_3000, 5'd0, 32'h55, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge CLK);
    check("bub_ret",   W_RETIRED, 32'd2);
    check("x0_wren",   {31'd0, W_REG_WREN}, 32'd0);
    check("x0_wvld",   {31'd0, W_VALID}, 32'd1);
    check("idle_rdy",  xfers, 32'd1);

    // Back-to-back stores with WREADY tied high.
    drive(1'b1, 32'h0000_3004, 5'd0, 32'h0, 1'b1, 32'h100, 4'hF, 32'h1111);
    @(negedge CLK);
    check("x0_ret",    W_RETIRED, 32'd3);
    check("b2b_wv0",   {31'd0, dmem_if.DATA_WVALID}, 32'd1);
    check("b2b_addr0", dmem_if.DATA_WADDR, 32'h100);
    check("b2b_st0",   {31'd0, STALL_REQ}, 32'd0);
    drive(1'b1, 32'h0000_3008, 5'd0, 32'h0, 1'b1, 32'h104, 4'hF, 32'h2222);
    @(negedge CLK);
    check("b2b_wv1",   {31'd0, dmem_if.DATA_WVALID}, 32'd1);
    check("b2b_addr1", dmem_if.DATA_WADDR, 32'h104);
    check("b2b_data1", dmem_if.DATA_WDATA, 32'h2222);
    check("b2b_st1",   {31'd0, STALL_REQ}, 32'd0);
    check("b2b_x0",    xfers, 32'd2);
    check("b2b_ret0",  W_RETIRED, 32'd4);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge CLK);
    check("b2b_x1",    xfers, 32'd3);
    check("b2b_last",  last_addr, 32'h104);
    check("b2b_ret1",  W_RETIRED, 32'd5);
    check("b2b_end",   {31'd0, dmem_if.DATA_WVALID}, 32'd0);

    // Reset while a store is stalled.
    dmem_if.DATA_WREADY = 1'b0;
    drive(1'b1, 32'h0000_4000, 5'd0, 32'h0, 1'b1, 32'h300, 4'h1, 32'h77);
    @(negedge CLK);
    check("mid_wvalid", {31'd0, dmem_if.DATA_WVALID}, 32'd1);
    check("mid_stall",  {31'd0, STALL_REQ}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("mrst_wvalid", {31'd0, dmem_if.DATA_WVALID}, 32'd0);
    check("mrst_stall",  {31'd0, STALL_REQ}, 32'd0);
    check("mrst_ret",    W_RETIRED, 32'd0);
    check("mrst_xfer",   xfers, 32'd3);
    RST = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge CLK);
    check("post_ret", W_RETIRED, 32'd0);

    // Preset the counter one below wrap, then retire once.
    dut.u_retire.cnt_q = 32'hFFFF_FFFF;
    drive(1'b1, 32'h0000_5000, 5'd3, 32'hABC, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge CLK);
    check("pre_wrap", W_RETIRED, 32'hFFFF_FFFF);
    check("wrap_wren", {31'd0, W_REG_WREN}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge CLK);
    check("wrap", W_RETIRED, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
